// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter.
// The controller (master) drives the action requests and observes the counter state.
interface mod_counter_if #(
  parameter int WIDTH = 4
);

  logic             sync_clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             up;

  logic [WIDTH-1:0] count;
  logic             limit;
  logic             overflow;
  logic             at_max;
  logic             at_zero;

  modport master (
    output sync_clear, load, load_value, enable, up,
    input  count, limit, overflow, at_max, at_zero
  );

  modport slave (
    input  sync_clear, load, load_value, enable, up,
    output count, limit, overflow, at_max, at_zero
  );

endinterface

// File: rtl/mod_counter.sv
// Up/down modulo counter with terminal count MAX_VALUE.
// Boundary steps either wrap (SATURATE=0) or hold (SATURATE=1). Every boundary
// step raises a one-cycle limit pulse and sets the sticky overflow flag.
module mod_counter #(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_VALUE = 15,
  parameter int          SATURATE  = 0
) (
  input  logic          clock,
  input  logic          clear_n,
  mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAXV = MAX_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               SAT  = (SATURATE != 0);

  // The single action taken on an edge, in priority order.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_CLEAR = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_STEP  = 2'd3
  } action_t;

  action_t          action;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             limit_q;
  logic             limit_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             boundary;

  // Select the action for this edge: sync_clear > load > enable > hold.
  always_comb begin
    action = ACT_HOLD;
    if (bus.sync_clear) begin
      action = ACT_CLEAR;
    end else if (bus.load) begin
      action = ACT_LOAD;
    end else if (bus.enable) begin
      action = ACT_STEP;
    end
  end

  // A step is a boundary step when it would leave the range [0, MAXV].
  always_comb begin
    boundary = bus.up ? (count_q == MAXV) : (count_q == '0);
  end

  // Next-state values for count, limit and overflow.
  always_comb begin
    count_d    = count_q;
    limit_d    = 1'b0;
    overflow_d = overflow_q;
    unique case (action)
      ACT_CLEAR: begin
        count_d    = '0;
        overflow_d = 1'b0;
      end
      ACT_LOAD: begin
        count_d = (bus.load_value > MAXV) ? MAXV : bus.load_value;
      end
      ACT_STEP: begin
        if (boundary) begin
          limit_d    = 1'b1;
          overflow_d = 1'b1;
          if (!SAT) begin
            count_d = bus.up ? '0 : MAXV;
          end
        end else if (bus.up) begin
          count_d = count_q + ONE;
        end else begin
          count_d = count_q - ONE;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // State registers; clear_n discards everything immediately.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count_q    <= '0;
      limit_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      limit_q    <= limit_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.limit    = limit_q;
  assign bus.overflow = overflow_q;
  assign bus.at_max   = (count_q == MAXV);
  assign bus.at_zero  = (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: WIDTH=4, MAX_VALUE=9, wrapping and saturating.
module tb_mod_counter;

  logic clock;
  logic clear_n;

  mod_counter_if #(.WIDTH(4)) b0 ();
  mod_counter_if #(.WIDTH(4)) b1 ();

  mod_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(0)) dut0 (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (b0)
  );

  mod_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1)) dut1 (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       sc;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       up;
    logic [3:0] c;
    logic       lim;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [3:0] c, input logic lim, input logic ovf);
    chk({tag, " count"},    int'(b0.count),    int'(c));
    chk({tag, " limit"},    int'(b0.limit),    int'(lim));
    chk({tag, " overflow"}, int'(b0.overflow), int'(ovf));
    chk({tag, " at_max"},   int'(b0.at_max),   int'(c == 4'd9));
    chk({tag, " at_zero"},  int'(b0.at_zero),  int'(c == 4'd0));
  endtask

  task automatic chk1(input string tag, input logic [3:0] c, input logic lim, input logic ovf);
    chk({tag, " count"},    int'(b1.count),    int'(c));
    chk({tag, " limit"},    int'(b1.limit),    int'(lim));
    chk({tag, " overflow"}, int'(b1.overflow), int'(ovf));
    chk({tag, " at_max"},   int'(b1.at_max),   int'(c == 4'd9));
  endtask

  task automatic drive0(input logic sc, input logic ld, input logic [3:0] lv,
                        input logic en, input logic up);
    b0.sync_clear = sc;
    b0.load       = ld;
    b0.load_value = lv;
    b0.enable     = en;
    b0.up         = up;
  endtask

  task automatic drive1(input logic sc, input logic ld, input logic [3:0] lv,
                        input logic en, input logic up);
    b1.sync_clear = sc;
    b1.load       = ld;
    b1.load_value = lv;
    b1.enable     = en;
    b1.up         = up;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic sc, input logic ld, input logic [3:0] lv, input logic en,
                     input logic up, input logic [3:0] c, input logic lim, input logic ovf);
    vec_t v;
    v.sc = sc; v.ld = ld; v.lv = lv; v.en = en; v.up = up;
    v.c = c; v.lim = lim; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    drive0(0, 0, 4'd0, 0, 0);
    drive1(0, 0, 4'd0, 0, 0);
    clear_n = 1'b0;
    #2;
    chk0("reset", 4'd0, 1'b0, 1'b0);
    chk1("reset sat", 4'd0, 1'b0, 1'b0);
    tick();
    clear_n = 1'b1;

    // Count up 1..9 then wrap, decrement wrap, direction change, loads, clears.
    for (int i = 1; i <= 9; i++) add(0, 0, 4'd0, 1, 1, 4'(i), 0, 0);
    add(0, 0, 4'd0,  1, 1, 4'd0, 1, 1);
    add(0, 0, 4'd0,  0, 0, 4'd0, 0, 1);
    add(0, 0, 4'd0,  1, 0, 4'd9, 1, 1);
    add(0, 0, 4'd0,  1, 0, 4'd8, 0, 1);
    add(0, 0, 4'd0,  1, 0, 4'd7, 0, 1);
    add(0, 0, 4'd0,  1, 1, 4'd8, 0, 1);
    add(0, 1, 4'd12, 0, 0, 4'd9, 0, 1);
    add(0, 1, 4'd3,  1, 1, 4'd3, 0, 1);
    add(0, 0, 4'd0,  1, 1, 4'd4, 0, 1);
    add(1, 1, 4'd5,  1, 1, 4'd0, 0, 0);
    add(0, 1, 4'd9,  0, 0, 4'd9, 0, 0);
    add(0, 0, 4'd0,  1, 1, 4'd0, 1, 1);
    add(0, 1, 4'd5,  1, 0, 4'd5, 0, 1);
    add(0, 1, 4'd15, 0, 0, 4'd9, 0, 1);
    add(1, 0, 4'd0,  0, 0, 4'd0, 0, 0);
    add(0, 0, 4'd0,  1, 1, 4'd1, 0, 0);

    foreach (vecs[i]) begin
      drive0(vecs[i].sc, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up);
      tick();
      chk0($sformatf("vec%0d", i), vecs[i].c, vecs[i].lim, vecs[i].ovf);
    end

    // Asynchronous reset mid-count with overflow set.
    drive0(0, 1, 4'd9, 0, 0); tick();
    drive0(0, 0, 4'd0, 1, 1); tick();
    chk0("pre-rst wrap", 4'd0, 1'b1, 1'b1);
    tick(); tick(); tick();
    chk0("pre-rst count", 4'd3, 1'b0, 1'b1);
    #2;
    clear_n = 1'b0;
    #1;
    chk0("async rst", 4'd0, 1'b0, 1'b0);
    tick();
    chk0("rst held", 4'd0, 1'b0, 1'b0);
    clear_n = 1'b1;
    tick();
    chk0("rst resume", 4'd1, 1'b0, 1'b0);
    drive0(0, 0, 4'd0, 0, 0);

    // Saturating instance: repeated boundary steps hold count and limit.
    drive1(0, 1, 4'd9, 0, 0); tick();
    chk1("sat load", 4'd9, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive1(0, 0, 4'd0, 1, 1); tick();
      chk1($sformatf("sat up%0d", i), 4'd9, 1'b1, 1'b1);
    end
    drive1(0, 0, 4'd0, 1, 0); tick();
    chk1("sat down", 4'd8, 1'b0, 1'b1);
    drive1(0, 1, 4'd0, 0, 0); tick();
    chk1("sat load0", 4'd0, 1'b0, 1'b1);
    drive1(0, 0, 4'd0, 1, 0); tick();
    chk1("sat dn0 a", 4'd0, 1'b1, 1'b1);
    tick();
    chk1("sat dn0 b", 4'd0, 1'b1, 1'b1);
    drive1(0, 0, 4'd0, 0, 0); tick();
    chk1("sat hold", 4'd0, 1'b0, 1'b1);
    drive1(1, 1, 4'd7, 1, 1); tick();
    chk1("sat clr+load", 4'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX_VALUE, default 15: terminal count, legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.
REQ-004 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port clear_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port sync_clear, input, 1: synchronous clear to zero.
REQ-007 SHALL have port load, input, 1: synchronous load of load_value.
REQ-008 SHALL have port load_value, input, WIDTH: value to load.
REQ-009 SHALL have port enable, input, 1: count-step enable.
REQ-010 SHALL have port up, input, 1: step direction, 1 = increment, 0 = decrement.
REQ-011 SHALL have port count, output, WIDTH: registered counter value.
REQ-012 SHALL have port limit, output, 1: registered one-cycle pulse marking a boundary event.
REQ-013 SHALL have port overflow, output, 1: registered sticky boundary-event flag.
REQ-014 SHALL have port at_max, output, 1: combinational, count == MAX_VALUE.
REQ-015 SHALL have port at_zero, output, 1: combinational, count == 0.

Function
REQ-016 SHALL apply at most one action per edge, priority sync_clear > load > enable; with none asserted, count holds.
REQ-017 sync_clear SHALL set count=0 and overflow=0 and limit=0 on the next edge.
REQ-018 load SHALL set count=min(load_value, MAX_VALUE); load_value > MAX_VALUE clamps to MAX_VALUE.
REQ-019 load SHALL not change overflow and SHALL force limit=0 on that edge.
REQ-020 enable with up=1 and count<MAX_VALUE SHALL give count+1; enable with up=0 and count>0 SHALL give count-1; each step takes effect on the next edge, single-cycle latency.
REQ-021 A boundary step is enable with (up=1, count==MAX_VALUE) or (up=0, count==0); these are the only boundary steps.
REQ-022 With SATURATE=0, a boundary step up SHALL give count=0 and a boundary step down SHALL give count=MAX_VALUE.
REQ-023 With SATURATE=1, a boundary step SHALL leave count unchanged.
REQ-024 limit SHALL be 1 for exactly the cycle after each edge that performs a boundary step, and 0 otherwise.
REQ-025 Back-to-back boundary steps (possible with SATURATE=1) SHALL keep limit high for every such cycle.
REQ-026 overflow SHALL be set on any boundary step and held until sync_clear or reset.
REQ-027 Changing up while enabled SHALL take effect on the very next edge, with no dead cycle.
REQ-028 Arithmetic SHALL be WIDTH-bit unsigned; count SHALL never exceed MAX_VALUE after any edge, including edges following a load.

Reset
REQ-029 clear_n low SHALL immediately, without waiting for a clock edge, force count=0, limit=0 and overflow=0, regardless of the other inputs.
REQ-030 While clear_n is low, all inputs SHALL be ignored; the first action SHALL be taken on the first rising edge after clear_n returns high.
REQ-031 Asserting clear_n mid-count SHALL discard all state, with no partial update.

Verification
REQ-032 (WIDTH=4, MAX_VALUE=9, SATURATE=0) Reset, then enable=1, up=1 for 10 edges -> count 1..9 then 0; limit high only in the cycle count returns to 0; overflow=1 from then on.
REQ-033 (same config) From count=0, enable=1, up=0 -> next count=9, limit pulses once; continued stepping gives 8, 7, ...
REQ-034 (same config) load=1, load_value=12 -> count=9; load=1, load_value=3 with enable=1, up=1 in the same cycle -> count=3, not 4.
REQ-035 (SATURATE=1) At count=9, enable=1, up=1 for 3 edges -> count stays 9, limit high for 3 consecutive cycles, overflow=1.
REQ-036 (any config) Assert sync_clear and load together with overflow=1 -> count=0, overflow=0.
REQ-037 (any config) Drop clear_n between edges mid-count -> count=0, overflow=0 before the next edge; counting resumes from 1 after release.
